controle_jogo: RTL
==================

Name: controle_jogo

Overview:
- Game-control front end of the naval-battle board.
- Takes the raw button and switch inputs and produces everything the 4-digit multiplexed 7-segment display driver consumes: mode flags, digit-scan counter, latched coordinates, selected map and remaining life.
- Runs the PREPARACAO/ATAQUE game flow.
- Issues shot requests to the map-lookup block and accounts hits and misses until victory or defeat.

Parameters:
- DEBOUNCE_CICLOS, 4, consecutive stable samples needed before a button level is accepted.
- DIV_REFRESH, 50000, clock cycles per digit-scan step of contador.
- VIDA_INICIAL, 5, lives loaded at the start of ATAQUE (3-bit, 1..7).
- NUM_ALVOS, 3, hits required for victory (1..7).
- GRID, 5, valid coordinate range 0..GRID-1 for column and row.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- botao_liga  input  1  power toggle button, active-high raw.
- botao_confirma  input  1  confirm button, active-high raw.
- chaves_mapa  input  3  map selection switches.
- chaves_coluna  input  3  column switches.
- chaves_linha  input  3  row switches.
- resposta_valida  input  1  map-lookup response strobe, one cycle.
- acerto  input  1  hit flag, sampled only with resposta_valida.
- ATAQUE  output  1  mode flag.
- PREPARACAO  output  1  mode flag.
- DESLIGADO  output  1  mode flag.
- contador  output  2  display digit select.
- coordColuna  output  3  latched shot column.
- coordLinha  output  3  latched shot row.
- mapa  output  3  selected map.
- vida  output  3  remaining lives.
- disparo  output  1  one-cycle shot request.
- vitoria  output  1  level, game won.
- derrota  output  1  level, game lost.

Behaviour:
- Reset values (asynchronous): state DESLIGADO, DESLIGADO=1, ATAQUE=0, PREPARACAO=0, contador=0, coordColuna=0, coordLinha=0, mapa=0, vida=0, disparo=0, vitoria=0, derrota=0, hit counter=0, debounce state cleared.
- Button input path:
  - Each button goes through a 2-flop synchronizer, then a debouncer.
  - A debounced level changes only after DEBOUNCE_CICLOS consecutive equal synchronized samples.
  - A rising edge of the debounced level produces a one-cycle event (ev_liga, ev_conf).
  - Latency from a stable raw press to the event is 2 + DEBOUNCE_CICLOS + 1 cycles.
  - Holding a button produces a single event.
- contador:
  - Free-running in every state, including DESLIGADO.
  - Increments by 1 every DIV_REFRESH cycles and wraps from 3 to 0.
- FSM states: DESLIGADO, PREPARACAO, ATAQUE, CONSULTA, FIM.
  - DESLIGADO: ev_liga -> PREPARACAO.
  - PREPARACAO: mapa <= chaves_mapa every cycle. ev_conf -> ATAQUE with vida <= VIDA_INICIAL and hit counter <= 0; mapa is frozen from then on.
  - ATAQUE:
    - ev_conf with chaves_coluna < GRID and chaves_linha < GRID: latch both into coordColuna/coordLinha and go to CONSULTA.
    - disparo=1 for exactly the first cycle in CONSULTA.
    - ev_conf with either coordinate >= GRID is ignored; state and coordinates are unchanged.
  - CONSULTA: waits indefinitely for resposta_valida.
    - acerto=1: hit counter +1. If the new count equals NUM_ALVOS, go to FIM with vitoria=1; otherwise return to ATAQUE.
    - acerto=0: vida -1. If the new vida is 0, go to FIM with derrota=1; otherwise return to ATAQUE.
    - ev_conf in CONSULTA is ignored.
  - FIM: ev_conf -> PREPARACAO, clearing vitoria, derrota, vida and the hit counter.
  - ev_liga in any state other than DESLIGADO -> DESLIGADO, clearing vida, coordinates, flags and the hit counter. mapa is retained.
  - ev_liga has priority over ev_conf and resposta_valida in the same cycle.
- resposta_valida outside CONSULTA is ignored.
- vida never underflows; the decrement happens only from a value of at least 1.
- Mode flags are registered and one-hot:
  - DESLIGADO=1 in DESLIGADO.
  - PREPARACAO=1 in PREPARACAO.
  - ATAQUE=1 in ATAQUE, CONSULTA and FIM.

Test Plan:
- Settings for all scenarios: DEBOUNCE_CICLOS=4, DIV_REFRESH=4, VIDA_INICIAL=2, NUM_ALVOS=2, GRID=5.
- Reset, then hold all inputs at 0 for 40 cycles -> DESLIGADO=1, all other outputs 0. contador steps 0,1,2,3,0 every 4 cycles.
- Press liga for 10 cycles with a 2-cycle glitch before it -> exactly one transition to PREPARACAO, 7 cycles after the stable press. The glitch causes no event.
- In PREPARACAO set chaves_mapa=3 and confirm -> ATAQUE=1, mapa=3, vida=2. Changing chaves_mapa to 6 afterwards leaves mapa=3.
- In ATAQUE:
  - Set coluna=5, linha=1 and confirm -> no disparo, coordinates unchanged.
  - Set coluna=2, linha=4 and confirm -> disparo pulse of 1 cycle, coordColuna=2, coordLinha=4.
- Answer two misses -> vida 2 -> 1 -> 0, derrota=1. Confirm -> PREPARACAO=1, derrota=0.
- Restart and answer two hits -> vitoria=1, vida=2.
- Second scenario: press liga while in CONSULTA, with resposta_valida in the same cycle -> DESLIGADO=1, vida=0, no hit or miss accounted.

Source files
------------

// File: rtl/controle_jogo_if.sv
// Bundle of every non-clock signal of the naval-battle game controller.
// Latency: n/a (wiring only).
// Backpressure: none; strobes are single-cycle and unacknowledged.
//
// master: the controller side. It reads the buttons, switches and map-lookup
//         response, and drives the mode flags, display fields and shot request.
// slave : the board/environment side, which has the opposite directions.
interface controle_jogo_if;
  logic       botao_liga;
  logic       botao_confirma;
  logic [2:0] chaves_mapa;
  logic [2:0] chaves_coluna;
  logic [2:0] chaves_linha;
  logic       resposta_valida;
  logic       acerto;
  logic       ATAQUE;
  logic       PREPARACAO;
  logic       DESLIGADO;
  logic [1:0] contador;
  logic [2:0] coordColuna;
  logic [2:0] coordLinha;
  logic [2:0] mapa;
  logic [2:0] vida;
  logic       disparo;
  logic       vitoria;
  logic       derrota;

  modport master (
    input  botao_liga, botao_confirma, chaves_mapa, chaves_coluna, chaves_linha,
           resposta_valida, acerto,
    output ATAQUE, PREPARACAO, DESLIGADO, contador, coordColuna, coordLinha,
           mapa, vida, disparo, vitoria, derrota
  );

  modport slave (
    output botao_liga, botao_confirma, chaves_mapa, chaves_coluna, chaves_linha,
           resposta_valida, acerto,
    input  ATAQUE, PREPARACAO, DESLIGADO, contador, coordColuna, coordLinha,
           mapa, vida, disparo, vitoria, derrota
  );
endinterface

// File: rtl/controle_jogo.sv
// Game-control front end for the naval-battle board. It debounces the buttons,
// runs the on/prepare/attack flow, scans the display digits and accounts shots.
// Latency: a stable raw press becomes an event after 2 + DEBOUNCE_CICLOS + 1 cycles.
// Backpressure: none. CONSULTA waits indefinitely for resposta_valida.
//
// Ports: clock, reset (async, active-high), bus (controle_jogo_if.master).
module controle_jogo #(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int DIV_REFRESH     = 50000,
  parameter int VIDA_INICIAL    = 5,
  parameter int NUM_ALVOS       = 3,
  parameter int GRID            = 5
) (
  input  logic clock,
  input  logic reset,
  controle_jogo_if.master bus
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam int DW = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;

  // The mode register is {ATAQUE, PREPARACAO, DESLIGADO}.
  localparam logic [2:0] M_DESL = 3'b001;
  localparam logic [2:0] M_PREP = 3'b010;
  localparam logic [2:0] M_ATQ  = 3'b100;

  typedef enum logic [2:0] {
    S_DESLIGADO, S_PREPARACAO, S_ATAQUE, S_CONSULTA, S_FIM
  } estado_t;

  // ---------------- Button path: sync, debounce, rising-edge event ----------
  // Bit 0 is liga and bit 1 is confirma.
  logic [1:0]    raw, sync1, sync2, deb, deb_q;
  logic [CW-1:0] cnt [2];
  logic          ev_liga, ev_conf;

  assign raw = {bus.botao_confirma, bus.botao_liga};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      // The counter tracks consecutive samples that disagree with the accepted
      // level. Any agreeing sample restarts the run, so glitches are dropped.
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CICLOS - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign ev_liga = deb[0] & ~deb_q[0];
  assign ev_conf = deb[1] & ~deb_q[1];

  // ---------------- Digit-scan counter (free-running) ------------------------
  logic [DW-1:0] div;
  logic [1:0]    contador_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div        <= '0;
      contador_r <= '0;
    end else if (div == DW'(DIV_REFRESH - 1)) begin
      div        <= '0;
      contador_r <= contador_r + 2'd1;
    end else begin
      div <= div + DW'(1);
    end
  end

  // ---------------- Game FSM --------------------------------------------------
  estado_t    estado;
  logic [2:0] modo, vida_r, col_r, lin_r, mapa_r, acertos;
  logic       disparo_r, vit_r, der_r;
  logic       coord_ok;

  assign coord_ok = ({1'b0, bus.chaves_coluna} < 4'(GRID)) &&
                    ({1'b0, bus.chaves_linha}  < 4'(GRID));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= S_DESLIGADO;
      modo      <= M_DESL;
      vida_r    <= '0;
      col_r     <= '0;
      lin_r     <= '0;
      mapa_r    <= '0;
      acertos   <= '0;
      disparo_r <= 1'b0;
      vit_r     <= 1'b0;
      der_r     <= 1'b0;
    end else begin
      disparo_r <= 1'b0;
      // Power-off wins over everything else that happens in the same cycle.
      if (ev_liga && estado != S_DESLIGADO) begin
        estado  <= S_DESLIGADO;
        modo    <= M_DESL;
        vida_r  <= '0;
        col_r   <= '0;
        lin_r   <= '0;
        acertos <= '0;
        vit_r   <= 1'b0;
        der_r   <= 1'b0;
      end else begin
        case (estado)
          S_DESLIGADO: if (ev_liga) begin
            estado <= S_PREPARACAO;
            modo   <= M_PREP;
          end
          S_PREPARACAO: begin
            mapa_r <= bus.chaves_mapa;
            if (ev_conf) begin
              estado  <= S_ATAQUE;
              modo    <= M_ATQ;
              vida_r  <= 3'(VIDA_INICIAL);
              acertos <= '0;
            end
          end
          S_ATAQUE: if (ev_conf && coord_ok) begin
            col_r     <= bus.chaves_coluna;
            lin_r     <= bus.chaves_linha;
            estado    <= S_CONSULTA;
            disparo_r <= 1'b1;
          end
          S_CONSULTA: if (bus.resposta_valida) begin
            if (bus.acerto) begin
              acertos <= acertos + 3'd1;
              if (acertos + 3'd1 == 3'(NUM_ALVOS)) begin
                estado <= S_FIM;
                vit_r  <= 1'b1;
              end else begin
                estado <= S_ATAQUE;
              end
            end else if (vida_r <= 3'd1) begin
              // The last life is gone. vida saturates at zero.
              vida_r <= '0;
              estado <= S_FIM;
              der_r  <= 1'b1;
            end else begin
              vida_r <= vida_r - 3'd1;
              estado <= S_ATAQUE;
            end
          end
          S_FIM: if (ev_conf) begin
            estado  <= S_PREPARACAO;
            modo    <= M_PREP;
            vit_r   <= 1'b0;
            der_r   <= 1'b0;
            vida_r  <= '0;
            acertos <= '0;
          end
          default: begin
            estado <= S_DESLIGADO;
            modo   <= M_DESL;
          end
        endcase
      end
    end
  end

  assign bus.DESLIGADO   = modo[0];
  assign bus.PREPARACAO  = modo[1];
  assign bus.ATAQUE      = modo[2];
  assign bus.contador    = contador_r;
  assign bus.coordColuna = col_r;
  assign bus.coordLinha  = lin_r;
  assign bus.mapa        = mapa_r;
  assign bus.vida        = vida_r;
  assign bus.disparo     = disparo_r;
  assign bus.vitoria     = vit_r;
  assign bus.derrota     = der_r;

endmodule
